fpu_issue: RTL and testbench
============================

FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 4, meaning width of the request/response tag.
REQ-002 SHALL have parameter RESP_DEPTH, default 2, meaning response buffer entries (power of two, >=2).
REQ-003 SHALL have port Clk_CI  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_RI  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports Req_valid_SI input 1 and Req_ready_SO output 1, the request handshake.
REQ-006 SHALL have ports Req_op_a_DI / Req_op_b_DI input C_OP, Req_op_DI input C_CMD, Req_rm_DI input C_RM and Req_tag_DI input TAG_WIDTH, the request payload.
REQ-007 SHALL have ports Fpu_enable_SO output 1, Fpu_op_a_DO / Fpu_op_b_DO output C_OP, Fpu_op_SO output C_CMD and Fpu_rm_SO output C_RM, driving the FPU core inputs.
REQ-008 SHALL have ports Fpu_result_DI input C_OP, Fpu_valid_SI input 1 and Fpu_flags_DI input 6, the FPU core outputs.
REQ-009 SHALL order all 6-bit flag vectors as {IV,OF,UF,Zero,IX,Inf}, MSB first.
REQ-010 SHALL have ports Resp_valid_SO output 1, Resp_ready_SI input 1, Resp_result_DO output C_OP, Resp_tag_DO output TAG_WIDTH and Resp_flags_DO output 6, the response handshake and payload.
REQ-011 SHALL have ports Fflags_DO output 6 (sticky flags) and Fflags_clr_SI input 1 (clear sticky flags).

Function
REQ-012 SHALL accept a request in every cycle in which Req_valid_SI and Req_ready_SO are both high ("issue").
REQ-013 SHALL drive Fpu_enable_SO combinationally as Req_valid_SI & Req_ready_SO, and drive Fpu_op_a_DO, Fpu_op_b_DO, Fpu_op_SO and Fpu_rm_SO combinationally from the request payload.
REQ-014 SHALL account for the FPU as fixed one-cycle latency: the result of an issue in cycle t is presented on Fpu_valid_SI in cycle t+1.
REQ-015 SHALL hold one in-flight register (valid bit plus tag), set on issue and cleared in the following cycle unless a new issue occurs in that cycle.
REQ-016 SHALL push {Fpu_result_DI, in-flight tag, Fpu_flags_DI} into the response FIFO when Fpu_valid_SI is high and the in-flight valid bit is set.
REQ-017 SHALL ignore Fpu_valid_SI whenever the in-flight valid bit is clear.
REQ-018 SHALL drive Req_ready_SO = (count + inflight - pop) < RESP_DEPTH, where count is the FIFO occupancy, inflight is the in-flight valid bit, and pop = Resp_valid_SO & Resp_ready_SI; the FIFO therefore never overflows and the FPU is never stalled.
REQ-019 SHALL drive Resp_valid_SO from a registered non-empty flag and the response payload from the FIFO head; earliest response is cycle t+2 for an issue in cycle t.
REQ-020 SHALL sustain one issue per cycle indefinitely while Resp_ready_SI is held high.
REQ-021 SHALL keep Resp_valid_SO asserted and the response payload stable until popped, regardless of other activity.
REQ-022 SHALL handle a push and a pop in the same cycle with the count unchanged, and wrap the read/write pointers modulo RESP_DEPTH.
REQ-023 SHALL return responses in issue order.

Reset
REQ-024 SHALL, while Rst_RI is high at a clock edge, clear the FIFO pointers and count, the in-flight register and Fflags_DO.
REQ-025 SHALL drive the following values in the cycle after reset: Resp_valid_SO=0, Req_ready_SO=1 when Req_valid_SI is high, Fflags_DO=0; Resp_result_DO, Resp_tag_DO and Resp_flags_DO are don't-care while Resp_valid_SO=0.
REQ-026 SHALL discard in-flight and buffered results on reset mid-operation; a late Fpu_valid_SI after reset is ignored per REQ-017.

Configuration
REQ-027 SHALL implement the sticky flag register only when macro FPU_ISSUE_STICKY_FLAGS_EN is defined.
REQ-028 SHALL, with the macro defined, update Fflags_DO on each push: when Fflags_clr_SI is low, Fflags_DO <= Fflags_DO | pushed flags; when Fflags_clr_SI is high, Fflags_DO <= pushed flags, or 0 if no push occurs.
REQ-029 SHALL, without the macro, tie Fflags_DO to 0 and ignore Fflags_clr_SI; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover single op: issue tag 3 in cycle 0 with FPU result 0x40400000 and flags 0 in cycle 1 -> Resp_valid_SO=1 in cycle 2 with tag 3 and result 0x40400000.
REQ-031 SHALL cover back-to-back ops: 8 issues with tags 0..7 and Resp_ready_SI held at 1 -> Req_ready_SO stays 1 and responses return tags 0..7 in order, one per cycle.
REQ-032 SHALL cover backpressure: Resp_ready_SI=0 with continuous requests -> exactly 2 issues are accepted, then Req_ready_SO=0; raising Resp_ready_SI for one cycle -> one pop and one new issue.
REQ-033 SHALL cover sticky flags with the macro defined: push flags 0x02 then 0x20 -> Fflags_DO=0x22; assert Fflags_clr_SI in the same cycle as a push with flags 0x04 -> Fflags_DO=0x04.
REQ-034 SHALL cover reset mid-operation: assert Rst_RI in the cycle after an issue while Fpu_valid_SI=1 -> no response is produced, count=0, Resp_valid_SO=0.
REQ-035 SHALL cover spurious valid: Fpu_valid_SI=1 with nothing in flight -> no push and Resp_valid_SO stays 0.

Source files
------------

// File: rtl/fpu_issue.sv
// Issue/response wrapper around a fixed one-cycle-latency FPU core with an in-order response FIFO.
// Optional sticky exception flags are enabled by defining FPU_ISSUE_STICKY_FLAGS_EN.

module fpu_issue #(
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned RESP_DEPTH = 2,
    parameter int unsigned C_OP       = 32,
    parameter int unsigned C_CMD      = 4,
    parameter int unsigned C_RM       = 3
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,

    input  logic                 Req_valid_SI,
    output logic                 Req_ready_SO,
    input  logic [C_OP-1:0]      Req_op_a_DI,
    input  logic [C_OP-1:0]      Req_op_b_DI,
    input  logic [C_CMD-1:0]     Req_op_DI,
    input  logic [C_RM-1:0]      Req_rm_DI,
    input  logic [TAG_WIDTH-1:0] Req_tag_DI,

    output logic                 Fpu_enable_SO,
    output logic [C_OP-1:0]      Fpu_op_a_DO,
    output logic [C_OP-1:0]      Fpu_op_b_DO,
    output logic [C_CMD-1:0]     Fpu_op_SO,
    output logic [C_RM-1:0]      Fpu_rm_SO,

    input  logic [C_OP-1:0]      Fpu_result_DI,
    input  logic                 Fpu_valid_SI,
    input  logic [5:0]           Fpu_flags_DI,

    output logic                 Resp_valid_SO,
    input  logic                 Resp_ready_SI,
    output logic [C_OP-1:0]      Resp_result_DO,
    output logic [TAG_WIDTH-1:0] Resp_tag_DO,
    output logic [5:0]           Resp_flags_DO,

    output logic [5:0]           Fflags_DO,
    input  logic                 Fflags_clr_SI
);

    localparam int unsigned PtrW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned OccW   = CntW + 1;
    localparam int unsigned EntryW = C_OP + TAG_WIDTH + 6;

    logic [EntryW-1:0]    mem_q [RESP_DEPTH];
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 nonempty_q, nonempty_d;
    logic                 inflight_q, inflight_d;
    logic [TAG_WIDTH-1:0] inflight_tag_q, inflight_tag_d;

    logic                 issue, push, pop;
    logic [OccW-1:0]      occupancy;
    logic [EntryW-1:0]    head;

    assign pop  = nonempty_q & Resp_ready_SI;
    assign push = Fpu_valid_SI & inflight_q;

    // Reserve a slot for the in-flight result so the FPU never has to be stalled.
    assign occupancy    = {1'b0, count_q} + OccW'(inflight_q) - OccW'(pop);
    assign Req_ready_SO = occupancy < OccW'(RESP_DEPTH);
    assign issue        = Req_valid_SI & Req_ready_SO;

    assign Fpu_enable_SO = issue;
    assign Fpu_op_a_DO   = Req_op_a_DI;
    assign Fpu_op_b_DO   = Req_op_b_DI;
    assign Fpu_op_SO     = Req_op_DI;
    assign Fpu_rm_SO     = Req_rm_DI;

    always_comb begin
        inflight_d     = issue;
        inflight_tag_d = issue ? Req_tag_DI : inflight_tag_q;
        rd_ptr_d       = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        wr_ptr_d       = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        count_d        = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        nonempty_d = (count_d != '0);
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            nonempty_q     <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            nonempty_q     <= nonempty_d;
            inflight_q     <= inflight_d;
            inflight_tag_q <= inflight_tag_d;
        end
    end

    // Payload storage needs no reset; the valid flag qualifies it.
    always_ff @(posedge Clk_CI) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {Fpu_result_DI, inflight_tag_q, Fpu_flags_DI};
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign Resp_valid_SO  = nonempty_q;
    assign Resp_result_DO = head[EntryW-1 -: C_OP];
    assign Resp_tag_DO    = head[6 +: TAG_WIDTH];
    assign Resp_flags_DO  = head[5:0];

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    logic [5:0] fflags_q, fflags_d;

    always_comb begin
        fflags_d = fflags_q;
        if (Fflags_clr_SI) begin
            fflags_d = push ? Fpu_flags_DI : 6'h00;
        end else if (push) begin
            fflags_d = fflags_q | Fpu_flags_DI;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign Fflags_DO = fflags_q;
`else
    logic unused_fflags_clr;

    assign unused_fflags_clr = Fflags_clr_SI;
    assign Fflags_DO         = '0;
`endif

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: directed scenarios plus randomized traffic checked
// against a queue-based reference model; the bench also plays the one-cycle FPU core.

module tb_fpu_issue;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [5:0]  fl;
    } resp_t;

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    localparam bit Sticky = 1'b1;
`else
    localparam bit Sticky = 1'b0;
`endif

    logic        Clk_CI = 1'b0;
    logic        Rst_RI;
    logic        Req_valid_SI;
    logic        Req_ready_SO;
    logic [31:0] Req_op_a_DI, Req_op_b_DI;
    logic [3:0]  Req_op_DI;
    logic [2:0]  Req_rm_DI;
    logic [3:0]  Req_tag_DI;
    logic        Fpu_enable_SO;
    logic [31:0] Fpu_op_a_DO, Fpu_op_b_DO;
    logic [3:0]  Fpu_op_SO;
    logic [2:0]  Fpu_rm_SO;
    logic [31:0] Fpu_result_DI;
    logic        Fpu_valid_SI;
    logic [5:0]  Fpu_flags_DI;
    logic        Resp_valid_SO;
    logic        Resp_ready_SI;
    logic [31:0] Resp_result_DO;
    logic [3:0]  Resp_tag_DO;
    logic [5:0]  Resp_flags_DO;
    logic [5:0]  Fflags_DO;
    logic        Fflags_clr_SI;

    fpu_issue dut (
        .Clk_CI        (Clk_CI),
        .Rst_RI        (Rst_RI),
        .Req_valid_SI  (Req_valid_SI),
        .Req_ready_SO  (Req_ready_SO),
        .Req_op_a_DI   (Req_op_a_DI),
        .Req_op_b_DI   (Req_op_b_DI),
        .Req_op_DI     (Req_op_DI),
        .Req_rm_DI     (Req_rm_DI),
        .Req_tag_DI    (Req_tag_DI),
        .Fpu_enable_SO (Fpu_enable_SO),
        .Fpu_op_a_DO   (Fpu_op_a_DO),
        .Fpu_op_b_DO   (Fpu_op_b_DO),
        .Fpu_op_SO     (Fpu_op_SO),
        .Fpu_rm_SO     (Fpu_rm_SO),
        .Fpu_result_DI (Fpu_result_DI),
        .Fpu_valid_SI  (Fpu_valid_SI),
        .Fpu_flags_DI  (Fpu_flags_DI),
        .Resp_valid_SO (Resp_valid_SO),
        .Resp_ready_SI (Resp_ready_SI),
        .Resp_result_DO(Resp_result_DO),
        .Resp_tag_DO   (Resp_tag_DO),
        .Resp_flags_DO (Resp_flags_DO),
        .Fflags_DO     (Fflags_DO),
        .Fflags_clr_SI (Fflags_clr_SI)
    );

    always #5 Clk_CI = ~Clk_CI;

    // Reference model state
    resp_t      q_m[$];
    bit         infl_m;
    logic [3:0] infl_tag_m;
    logic [5:0] ff_m;
    logic [3:0] popped[$];
    int         en_cnt;
    int         checks;
    int         errors;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, update the model at posedge.
    task automatic step(input bit rv, input logic [3:0] tag, input bit rr, input bit fv,
                        input logic [31:0] res, input logic [5:0] fl, input bit clr,
                        input bit rst);
        bit         pop_m, rdy_m, iss_m, push_m;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [2:0]  rm;
        resp_t       e;
        @(negedge Clk_CI);
        a  = $urandom;
        b  = $urandom;
        op = 4'($urandom);
        rm = 3'($urandom);
        Rst_RI        = rst;
        Req_valid_SI  = rv;
        Req_tag_DI    = tag;
        Req_op_a_DI   = a;
        Req_op_b_DI   = b;
        Req_op_DI     = op;
        Req_rm_DI     = rm;
        Resp_ready_SI = rr;
        Fpu_valid_SI  = fv;
        Fpu_result_DI = res;
        Fpu_flags_DI  = fl;
        Fflags_clr_SI = clr;
        #1;
        pop_m = (q_m.size() != 0) && rr;
        rdy_m = (q_m.size() + int'(infl_m) - int'(pop_m)) < 2;
        iss_m = rv && rdy_m;
        if (Fpu_enable_SO === 1'b1) en_cnt++;
        if (!rst) begin
            chk("resp_valid", Resp_valid_SO, q_m.size() != 0);
            chk("req_ready", Req_ready_SO, rdy_m);
            chk("fpu_enable", Fpu_enable_SO, iss_m);
            chk("fpu_payload", {Fpu_op_a_DO, Fpu_op_b_DO[24:0], Fpu_op_SO, Fpu_rm_SO},
                {a, b[24:0], op, rm});
            chk("fflags", Fflags_DO, Sticky ? ff_m : 6'h00);
            if (q_m.size() != 0) begin
                chk("resp_payload", {Resp_result_DO, Resp_tag_DO, Resp_flags_DO}, q_m[0]);
            end
        end
        @(posedge Clk_CI);
        if (rst) begin
            q_m.delete();
            infl_m = 1'b0;
            ff_m   = 6'h00;
        end else begin
            push_m = fv && infl_m;
            if (pop_m) begin
                popped.push_back(q_m[0].tag);
                void'(q_m.pop_front());
            end
            if (push_m) begin
                e = {res, infl_tag_m, fl};
                q_m.push_back(e);
            end
            if (clr) ff_m = push_m ? fl : 6'h00;
            else if (push_m) ff_m = ff_m | fl;
            infl_m = iss_m;
            if (iss_m) infl_tag_m = tag;
        end
    endtask

    // FPU answers every issue exactly one cycle later.
    task automatic auto_step(input bit rv, input logic [3:0] tag, input bit rr);
        step(rv, tag, rr, infl_m, $urandom, 6'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        int n0;
        checks = 0;
        errors = 0;
        en_cnt = 0;
        infl_m = 1'b0;
        infl_tag_m = '0;
        ff_m = '0;
        Rst_RI = 1'b1; Req_valid_SI = 0; Req_tag_DI = 0; Req_op_a_DI = 0; Req_op_b_DI = 0;
        Req_op_DI = 0; Req_rm_DI = 0; Resp_ready_SI = 0; Fpu_valid_SI = 0;
        Fpu_result_DI = 0; Fpu_flags_DI = 0; Fflags_clr_SI = 0;

        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("reset_resp_valid", Resp_valid_SO, 1'b0);
        chk("reset_fflags", Fflags_DO, 6'h00);

        // Single op: tag 3, result 3.0
        step(1, 4'd3, 0, 0, 0, 0, 0, 0);
        #1 chk("single_not_early", Resp_valid_SO, 1'b0);
        step(0, 0, 0, 1, 32'h40400000, 6'h00, 0, 0);
        #1;
        chk("single_valid", Resp_valid_SO, 1'b1);
        chk("single_tag", Resp_tag_DO, 4'd3);
        chk("single_result", Resp_result_DO, 32'h40400000);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // Back-to-back: tags 0..7 with the consumer always ready
        popped.delete();
        en_cnt = 0;
        for (int i = 0; i < 8; i++) auto_step(1'b1, 4'(i), 1'b1);
        for (int i = 0; i < 3; i++) auto_step(1'b0, 4'd0, 1'b1);
        chk("b2b_issues", en_cnt, 8);
        chk("b2b_count", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++) chk("b2b_order", popped[i], 4'(i));

        // Backpressure: consumer stalled, requests continuous
        en_cnt = 0;
        for (int i = 0; i < 5; i++) auto_step(1'b1, 4'(8 + i), 1'b0);
        chk("bp_issues", en_cnt, 2);
        #1 chk("bp_ready_low", Req_ready_SO, 1'b0);
        en_cnt = 0;
        n0 = popped.size();
        auto_step(1'b1, 4'hc, 1'b1);
        chk("bp_one_issue", en_cnt, 1);
        chk("bp_one_pop", popped.size() - n0, 1);
        for (int i = 0; i < 4; i++) auto_step(1'b0, 4'd0, 1'b1);

        // Sticky flags
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 4'd1, 1, 0, 0, 6'h00, 0, 0);
        step(1, 4'd2, 1, 1, 32'h1, 6'h02, 0, 0);
        step(0, 0, 1, 1, 32'h2, 6'h20, 0, 0);
        #1 chk("sticky_or", Fflags_DO, Sticky ? 6'h22 : 6'h00);
        step(1, 4'd5, 1, 0, 0, 6'h00, 0, 0);
        step(0, 0, 1, 1, 32'h3, 6'h04, 1, 0);
        #1 chk("sticky_clr_push", Fflags_DO, Sticky ? 6'h04 : 6'h00);
        step(0, 0, 1, 0, 0, 6'h00, 1, 0);
        #1 chk("sticky_clr_only", Fflags_DO, 6'h00);

        // Reset while a result is returning
        step(1, 4'd6, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hdead, 6'h3f, 0, 1);
        #1 chk("rst_mid_valid", Resp_valid_SO, 1'b0);
        step(0, 0, 0, 1, 32'hbeef, 6'h3f, 0, 0);
        #1;
        chk("rst_late_valid", Resp_valid_SO, 1'b0);
        chk("rst_ready", Req_ready_SO, 1'b1);

        // Spurious FPU valid with nothing in flight
        step(0, 0, 0, 1, 32'h1234, 6'h01, 0, 0);
        step(0, 0, 0, 1, 32'h5678, 6'h01, 0, 0);
        #1 chk("spurious_valid", Resp_valid_SO, 1'b0);

        // Randomized traffic, including occasional spurious valids and flag clears
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
                 infl_m | ($urandom_range(0, 7) == 0), $urandom, 6'($urandom),
                 $urandom_range(0, 9) == 0, 1'b0);
        end
        for (int i = 0; i < 6; i++) auto_step(1'b0, 4'd0, 1'b1);
        chk("drain_empty", Resp_valid_SO, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
